// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT    = 2'b01,
        ABANDON = 2'b10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] WB_LOAD = 2'b01;

    // A producer only matters if it really writes a non-x0 register the consumer reads.
    function automatic logic reg_match(input logic [4:0] rd, input logic wren,
                                       input logic [4:0] rs);
        return wren && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for one EX operand; the younger M result beats the W result.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_M,
    input  logic       i_rd_wren_M,
    input  logic [4:0] i_rd_W,
    input  logic       i_rd_wren_W,
    output logic [1:0] o_fwd
);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (reg_match(i_rd_M, i_rd_wren_M, i_rs)) begin
            w_sel = FWD_M;
        end else if (reg_match(i_rd_W, i_rd_wren_W, i_rs)) begin
            w_sel = FWD_W;
        end
    end

    assign o_fwd = w_sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, stall and flush control for the 5-stage core, including data-memory wait/timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic             rd_wren_E,
    input  logic [1:0]       wb_sel_E,
    input  logic [4:0]       rd_M,
    input  logic             rd_wren_M,
    input  logic [4:0]       rd_W,
    input  logic             rd_wren_W,
    input  logic             br_taken_E,
    input  logic             mem_req_M,
    input  logic             mem_ack,
    output logic [1:0]       fwd_a_E,
    output logic [1:0]       fwd_b_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             bubble_W,
    output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [15:0] LAST_CNT = 16'(MEM_TIMEOUT - 1);

    generate
        if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
            $error("hazard_ctrl: illegal MEM_TIMEOUT or CNT_W");
        end
    endgenerate

    ctrl_state_e r_state;
    logic [15:0] r_wait_cnt;
    logic        r_mem_err;

    logic [4:0]  w_rs_E  [2];
    logic [1:0]  w_fwd   [2];
    logic        w_load_use;
    logic        w_mem_wait;

    assign w_rs_E[0] = rs1_E;
    assign w_rs_E[1] = rs2_E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .i_rs        (w_rs_E[gi]),
                .i_rd_M      (rd_M),
                .i_rd_wren_M (rd_wren_M),
                .i_rd_W      (rd_W),
                .i_rd_wren_W (rd_wren_W),
                .o_fwd       (w_fwd[gi])
            );
        end
    endgenerate

    assign fwd_a_E = rst ? FWD_RF : w_fwd[0];
    assign fwd_b_E = rst ? FWD_RF : w_fwd[1];

    assign w_load_use = (wb_sel_E == WB_LOAD) && rd_wren_E && (rd_E != 5'd0) &&
                        ((rd_E == rs1_D) || (rd_E == rs2_D));

    // The abandon cycle lets the stuck access drain through with whatever M holds.
    assign w_mem_wait = mem_req_M && !mem_ack && (r_state != ABANDON);

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        bubble_W = 1'b0;
        if (!rst) begin
            if (w_mem_wait) begin
                stall_F  = 1'b1;
                stall_D  = 1'b1;
                stall_E  = 1'b1;
                stall_M  = 1'b1;
                bubble_W = 1'b1;
            end else if (br_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (w_load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= 16'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= 16'd1;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= 16'd0;
                    end else if (r_wait_cnt == LAST_CNT) begin
                        r_state    <= ABANDON;
                        r_wait_cnt <= 16'd0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall_F && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (flush_D && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios then random traffic.
module tb_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       rd_wren_E, rd_wren_M, rd_wren_W;
    logic [1:0] wb_sel_E;
    logic       br_taken_E, mem_req_M, mem_ack;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_wren_E(rd_wren_E), .wb_sel_E(wb_sel_E),
        .rd_M(rd_M), .rd_wren_M(rd_wren_M), .rd_W(rd_W), .rd_wren_W(rd_wren_W),
        .br_taken_E(br_taken_E), .mem_req_M(mem_req_M), .mem_ack(mem_ack),
        .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .bubble_W(bubble_W), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  stall;   // {F,D,E,M}
        logic [1:0]  flush;   // {D,E}
        logic        bub;
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: how many cycles the current access has already stalled.
    int   m_stalled = 0;
    bit   m_err     = 1'b0;
    int   m_sc      = 0;
    int   m_fc      = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs != 0 && rd_wren_M && rd_M == rs) return 2'b10;
        if (rs != 0 && rd_wren_W && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step();
        exp_t e;
        bit   lu, waiting;
        e       = '0;
        lu      = (wb_sel_E == 2'b01) && rd_wren_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        waiting = mem_req_M && !mem_ack && (m_stalled < TO);
        e.err   = m_err;
        e.sc    = 16'(m_sc);
        e.fc    = 16'(m_fc);
        if (!rst) begin
            e.fa = ref_fwd(rs1_E);
            e.fb = ref_fwd(rs2_E);
            if (waiting) begin
                e.stall = 4'b1111;
                e.bub   = 1'b1;
            end else if (br_taken_E) begin
                e.flush = 2'b11;
            end else if (lu) begin
                e.stall = 4'b1100;
                e.flush = 2'b01;
            end
        end
        q.push_back(e);
        if (rst) begin
            m_stalled = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            if (waiting) begin
                m_stalled++;
                if (m_stalled == TO) m_err = 1'b1;
            end else begin
                m_stalled = 0;
            end
            if (e.stall[3] && m_sc != 16'hFFFF) m_sc++;
            if (e.flush[1] && m_fc != 16'hFFFF) m_fc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL cyc=%0d %s got=%h exp=%h", cyc, name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("fwd_a", {14'd0, fwd_a_E}, {14'd0, e.fa});
            check("fwd_b", {14'd0, fwd_b_E}, {14'd0, e.fb});
            check("stall", {12'd0, stall_F, stall_D, stall_E, stall_M}, {12'd0, e.stall});
            check("flush", {14'd0, flush_D, flush_E}, {14'd0, e.flush});
            check("bubble_W", {15'd0, bubble_W}, {15'd0, e.bub});
            check("mem_err", {15'd0, mem_err}, {15'd0, e.err});
`ifdef HAZARD_PERF_CNT_EN
            check("stall_cycles", 16'(stall_cycles), e.sc);
            check("flush_count", 16'(flush_count), e.fc);
`endif
            $display("cyc=%0d fa=%b fb=%b st=%b%b%b%b fl=%b%b bw=%b err=%b",
                     cyc, fwd_a_E, fwd_b_E, stall_F, stall_D, stall_E, stall_M,
                     flush_D, flush_E, bubble_W, mem_err);
        end
    end

    task automatic idle();
        rst = 1'b0;
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        rd_wren_E = 0; rd_wren_M = 0; rd_wren_W = 0; wb_sel_E = 2'b00;
        br_taken_E = 0; mem_req_M = 0; mem_ack = 0;
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        step();                                 // reset cycle
        idle();
        // lw x5 in E, add x6,x5,x2 in D
        wb_sel_E = 2'b01; rd_E = 5; rd_wren_E = 1; rs1_D = 5; rs2_D = 2; step();
        idle(); rs1_E = 5; rs2_E = 2; rd_W = 5; rd_wren_W = 1; step();
        // M beats W; x0 never forwarded
        idle(); rd_M = 3; rd_wren_M = 1; rd_W = 3; rd_wren_W = 1; rs1_E = 3; step();
        idle(); rd_M = 0; rd_wren_M = 1; rd_W = 0; rd_wren_W = 1; step();
        // taken branch over a load-use
        idle(); wb_sel_E = 2'b01; rd_E = 7; rd_wren_E = 1; rs2_D = 7; br_taken_E = 1; step();
        // x0 load never stalls
        idle(); wb_sel_E = 2'b01; rd_E = 0; rd_wren_E = 1; step();
        // 3-cycle memory wait, ack lands on the timeout cycle
        idle(); mem_req_M = 1;
        repeat (3) step();
        mem_ack = 1; step();
        // timeout: 4 stall cycles, one abandon cycle, sticky error
        idle(); mem_req_M = 1; br_taken_E = 1;
        repeat (5) step();
        idle(); repeat (2) step();
        // ack with request: no stall; back-to-back accesses
        mem_req_M = 1; mem_ack = 1; step();
        mem_ack = 0; step(); mem_ack = 1; step();
        mem_ack = 0; step(); step(); mem_ack = 1; step();
        // reset mid-wait
        idle(); mem_req_M = 1; repeat (2) step();
        rst = 1'b1; step();
        idle(); step(); step();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 150) == 0);
            rs1_D      = rnd_reg(); rs2_D = rnd_reg();
            rs1_E      = rnd_reg(); rs2_E = rnd_reg();
            rd_E       = rnd_reg(); rd_M = rnd_reg(); rd_W = rnd_reg();
            rd_wren_E  = 1'($urandom_range(0, 1));
            rd_wren_M  = 1'($urandom_range(0, 1));
            rd_wren_W  = 1'($urandom_range(0, 1));
            wb_sel_E   = 2'($urandom_range(0, 3));
            br_taken_E = ($urandom_range(0, 7) == 0);
            mem_ack    = ($urandom_range(0, 3) == 0);
            if (m_stalled > 0 && m_stalled < TO) mem_req_M = 1'b1;
            else mem_req_M = ($urandom_range(0, 2) == 0);
            step();
        end
        idle();
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
